kmeans_call_driver: RTL and testbench

Initiator for the `kmeans` HLS component's call/return interface. Accepts job descriptors (idx, num_clusters, num_dim) on a valid/ready job port, issues them as component calls honouring `busy`, captures each `returndata` under `stall` backpressure, and presents results in order on a valid/ready result port. Sits between the system-side job scheduler and the `kmeans` instance; credit accounting guarantees the result buffer never overflows.

---
 rtl/kmeans_drv_pkg.sv | 17 +
 rtl/kmeans_drv_fifo.sv | 70 +++++++
 rtl/kmeans_call_driver.sv | 138 +++++++++++++
 tb/tb_kmeans_call_driver.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_drv_pkg.sv
// Shared types for the kmeans call driver: FSM state, data width and job descriptor.
package kmeans_drv_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [0:0] {
      StIdle,
      StCall
   } drv_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] idx;
      logic [DATA_W-1:0] num_clusters;
      logic [DATA_W-1:0] num_dim;
   } job_desc_t;

endpackage

// File: rtl/kmeans_drv_fifo.sv
// Result FIFO for the kmeans call driver. The head word sits in an output register,
// so a push into an empty FIFO is visible on rdata_o one cycle later.
module kmeans_drv_fifo #(
   parameter int unsigned RES_DEPTH = 4,
   parameter int unsigned DATA_W    = kmeans_drv_pkg::DATA_W
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           push_i,
   input  logic [DATA_W-1:0]              wdata_i,
   input  logic                           pop_i,
   output logic [DATA_W-1:0]              rdata_o,
   output logic                           full_o,
   output logic                           empty_o,
   output logic [$clog2(RES_DEPTH+1)-1:0] count_o
);

   localparam int unsigned PtrW = $clog2(RES_DEPTH);
   localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

   logic [DATA_W-1:0] mem_q [RES_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
   logic [CntW-1:0]   count_q, count_d;
   logic [DATA_W-1:0] dout_q, dout_d;

   assign rd_next = rd_ptr_q + PtrW'(1);

   always_comb begin
      count_d = count_q;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Head register tracks mem_q[rd_ptr_q]; bypass wdata when the FIFO is (or becomes) empty.
   always_comb begin
      dout_d = dout_q;
      if (push_i && (count_q == '0 || (pop_i && count_q == CntW'(1)))) begin
         dout_d = wdata_i;
      end else if (pop_i && count_q > CntW'(1)) begin
         dout_d = mem_q[rd_next];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_i)  rd_ptr_q <= rd_next;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = dout_q;
   assign full_o  = (count_q == CntW'(RES_DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/kmeans_call_driver.sv
// Call/return initiator for the kmeans HLS component with credit-limited result buffering.
// Optional watchdog enabled by defining KMEANS_DRV_TIMEOUT_EN.
module kmeans_call_driver
   import kmeans_drv_pkg::*;
#(
   parameter int unsigned RES_DEPTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           job_valid,
   output logic                           job_ready,
   input  logic [31:0]                    job_idx,
   input  logic [31:0]                    job_num_clusters,
   input  logic [31:0]                    job_num_dim,
   output logic                           comp_start,
   input  logic                           comp_busy,
   output logic [31:0]                    comp_idx,
   output logic [31:0]                    comp_num_clusters,
   output logic [31:0]                    comp_num_dim,
   input  logic                           comp_done,
   output logic                           comp_stall,
   input  logic [31:0]                    comp_returndata,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [31:0]                    res_data,
   output logic [$clog2(RES_DEPTH+1)-1:0] outstanding,
   output logic                           timeout_err
);

   localparam int unsigned OutW = $clog2(RES_DEPTH + 1);

   drv_state_e      state_q, state_d;
   job_desc_t       args_q, args_d;
   logic [OutW-1:0] out_q, out_d;
   logic            call_fire, job_accept, ret_fire, push, pop;
   logic            fifo_full, fifo_empty;
   logic [OutW-1:0] unused_count;

   assign comp_start = (state_q == StCall);
   assign call_fire  = comp_start && !comp_busy;
   // Gated by resetn so the job port is closed while reset is held.
   assign job_ready  = resetn && (state_q == StIdle || call_fire) && (out_q < OutW'(RES_DEPTH));
   assign job_accept = job_valid && job_ready;
   assign ret_fire   = comp_done && !comp_stall;
   assign push       = ret_fire && (out_q != '0);
   assign pop        = res_valid && res_ready;

   always_comb begin
      state_d = state_q;
      args_d  = args_q;
      unique case (state_q)
         StIdle:  if (job_accept) state_d = StCall;
         StCall:  if (call_fire && !job_accept) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (job_accept) begin
         args_d = '{idx: job_idx, num_clusters: job_num_clusters, num_dim: job_num_dim};
      end
   end

   always_comb begin
      out_d = out_q;
      unique case ({job_accept, pop})
         2'b10:   out_d = out_q + OutW'(1);
         2'b01:   out_d = out_q - OutW'(1);
         default: out_d = out_q;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         args_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         args_q  <= args_d;
         out_q   <= out_d;
      end
   end

   kmeans_drv_fifo #(
      .RES_DEPTH (RES_DEPTH),
      .DATA_W    (DATA_W)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (resetn),
      .push_i  (push),
      .wdata_i (comp_returndata),
      .pop_i   (pop),
      .rdata_o (res_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (unused_count)
   );

   assign comp_idx          = args_q.idx;
   assign comp_num_clusters = args_q.num_clusters;
   assign comp_num_dim      = args_q.num_dim;
   assign comp_stall        = fifo_full;
   assign res_valid         = !fifo_empty;
   assign outstanding       = out_q;

`ifdef KMEANS_DRV_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

   logic [WdW-1:0] wd_q, wd_d;
   logic           err_q;

   // Saturates at the limit so the sticky flag cannot be missed on wrap.
   always_comb begin
      wd_d = wd_q;
      if (ret_fire || out_q == '0) begin
         wd_d = '0;
      end else if (wd_q != WdW'(TIMEOUT_CYCLES)) begin
         wd_d = wd_q + WdW'(1);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_q | (wd_d == WdW'(TIMEOUT_CYCLES));
      end
   end

   assign timeout_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_kmeans_call_driver.sv
// Self-checking bench for kmeans_call_driver; results are tracked in a scoreboard queue.
module tb_kmeans_call_driver;

   localparam int unsigned RES_DEPTH      = 4;
   localparam int unsigned TIMEOUT_CYCLES = 16;

   logic        clock = 1'b0;
   logic        resetn;
   logic        job_valid, job_ready;
   logic [31:0] job_idx, job_num_clusters, job_num_dim;
   logic        comp_start, comp_busy;
   logic [31:0] comp_idx, comp_num_clusters, comp_num_dim;
   logic        comp_done, comp_stall;
   logic [31:0] comp_returndata;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic [2:0]  outstanding;
   logic        timeout_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q [$];

   kmeans_call_driver #(
      .RES_DEPTH      (RES_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clock             (clock),
      .resetn            (resetn),
      .job_valid         (job_valid),
      .job_ready         (job_ready),
      .job_idx           (job_idx),
      .job_num_clusters  (job_num_clusters),
      .job_num_dim       (job_num_dim),
      .comp_start        (comp_start),
      .comp_busy         (comp_busy),
      .comp_idx          (comp_idx),
      .comp_num_clusters (comp_num_clusters),
      .comp_num_dim      (comp_num_dim),
      .comp_done         (comp_done),
      .comp_stall        (comp_stall),
      .comp_returndata   (comp_returndata),
      .res_valid         (res_valid),
      .res_ready         (res_ready),
      .res_data          (res_data),
      .outstanding       (outstanding),
      .timeout_err       (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; job_valid = 1'b0; job_idx = '0; job_num_clusters = '0; job_num_dim = '0;
      comp_busy = 1'b0; comp_done = 1'b0; comp_returndata = '0; res_ready = 1'b0;
      #3;
      n_checks++;
      if (job_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_job_ready: got %b want 0", job_ready);
      end
      n_checks++;
      if ({comp_start, comp_stall, res_valid, timeout_err} !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 0000", {comp_start, comp_stall, res_valid, timeout_err});
      end
      n_checks++;
      if ({comp_idx, comp_num_clusters, comp_num_dim, res_data} !== 128'h0 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL reset_values: args %h %h %h res %h out %0d want all 0",
                            comp_idx, comp_num_clusters, comp_num_dim, res_data, outstanding);
      end
      @(negedge clock);
      resetn = 1'b1;
      #1;
      n_checks++;
      if (job_ready !== 1'b1) begin
         n_fail++; $display("FAIL release_job_ready: got %b want 1", job_ready);
      end
   endtask

   task automatic test_single_job();
      tick();
      job_valid = 1'b1; job_idx = 32'd5; job_num_clusters = 32'd3; job_num_dim = 32'd2;
      #1;
      n_checks++;
      if (job_ready !== 1'b1) begin
         n_fail++; $display("FAIL single_ready: got %b want 1", job_ready);
      end
      tick();
      job_valid = 1'b0; job_idx = 32'hFFFF_FFFF; job_num_clusters = 32'hFFFF_FFFF;
      job_num_dim = 32'hFFFF_FFFF;
      #1;
      n_checks++;
      if (comp_start !== 1'b1 || {comp_idx, comp_num_clusters, comp_num_dim} !== {32'd5, 32'd3, 32'd2}
          || outstanding !== 3'd1) begin
         n_fail++; $display("FAIL single_call: start %b args %0d %0d %0d out %0d want 1 5 3 2 1",
                            comp_start, comp_idx, comp_num_clusters, comp_num_dim, outstanding);
      end
      tick();
      n_checks++;
      if (comp_start !== 1'b0 || comp_idx !== 32'd5) begin
         n_fail++; $display("FAIL single_one_cycle: start %b idx %0d want 0 5", comp_start, comp_idx);
      end
      comp_done = 1'b1; comp_returndata = 32'h1234; exp_q.push_back(32'h1234);
      #1;
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_latency: res_valid %b want 0 before edge", res_valid);
      end
      tick();
      comp_done = 1'b0;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
         n_fail++; $display("FAIL single_result: valid %b data %h want 1 %h", res_valid, res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_checks++;
      if (res_valid !== 1'b0 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL single_pop: valid %b out %0d want 0 0", res_valid, outstanding);
      end
   endtask

   task automatic test_busy_hold();
      int fires = 0;
      int bad = 0;
      comp_busy = 1'b1;
      job_valid = 1'b1; job_idx = 32'd7; job_num_clusters = 32'd8; job_num_dim = 32'd9;
      tick();
      job_valid = 1'b0; job_idx = '0; job_num_clusters = '0; job_num_dim = '0;
      for (int i = 0; i < 11; i++) begin
         if (i == 10) begin
            comp_busy = 1'b0;
            #1;
         end
         if (comp_start !== 1'b1 || {comp_idx, comp_num_clusters, comp_num_dim} !== {32'd7, 32'd8, 32'd9})
            bad++;
         if (comp_start && !comp_busy) fires++;
         tick();
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++; $display("FAIL busy_stable: %0d unstable cycles want 0", bad);
      end
      n_checks++;
      if (fires != 1) begin
         n_fail++; $display("FAIL busy_calls: %0d calls want 1", fires);
      end
      n_checks++;
      if (comp_start !== 1'b0) begin
         n_fail++; $display("FAIL busy_release: start %b want 0", comp_start);
      end
      comp_done = 1'b1; comp_returndata = 32'h77; exp_q.push_back(32'h77);
      tick();
      comp_done = 1'b0; res_ready = 1'b1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
         n_fail++; $display("FAIL busy_result: valid %b data %h want 1 %h", res_valid, res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_credit_limit();
      int sent = 0;
      int calls = 0;
      logic pend = 1'b0;
      logic [31:0] pend_val = '0;
      res_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         job_valid = (sent < 6); job_idx = 32'(100 + sent);
         comp_done = pend; comp_returndata = pend_val;
         if (pend) exp_q.push_back(pend_val);
         #1;
         if (job_valid && job_ready) sent++;
         pend = comp_start && !comp_busy;
         pend_val = comp_idx + 32'h1000;
         if (pend) calls++;
         tick();
      end
      comp_done = 1'b0;
      #1;
      n_checks++;
      if (calls != 4 || sent != 4) begin
         n_fail++; $display("FAIL credit_calls: calls %0d accepted %0d want 4 4", calls, sent);
      end
      n_checks++;
      if (job_ready !== 1'b0 || outstanding !== 3'd4 || comp_stall !== 1'b1) begin
         n_fail++; $display("FAIL credit_block: ready %b out %0d stall %b want 0 4 1",
                            job_ready, outstanding, comp_stall);
      end
      res_ready = 1'b1;
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
         n_fail++; $display("FAIL credit_first: valid %b data %h want 1 %h", res_valid, res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      res_ready = 1'b0;
      #1;
      n_checks++;
      if (job_ready !== 1'b1) begin
         n_fail++; $display("FAIL credit_reopen: ready %b want 1", job_ready);
      end
      tick();
      job_valid = 1'b0;
      #1;
      n_checks++;
      if (outstanding !== 3'd4 || comp_start !== 1'b1 || comp_idx !== 32'd104) begin
         n_fail++; $display("FAIL credit_fifth: out %0d start %b idx %0d want 4 1 104",
                            outstanding, comp_start, comp_idx);
      end
      tick();
      comp_done = 1'b1; comp_returndata = 32'h1068; exp_q.push_back(32'h1068);
      tick();
      comp_done = 1'b0; res_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         #1;
         n_checks++;
         if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
            n_fail++; $display("FAIL credit_drain: valid %b data %h want 1 %h", res_valid, res_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick();
      end
      res_ready = 1'b0;
      #1;
      n_checks++;
      if (outstanding !== 3'd0 || res_valid !== 1'b0) begin
         n_fail++; $display("FAIL credit_empty: out %0d valid %b want 0 0", outstanding, res_valid);
      end
   endtask

   task automatic test_ordering();
      logic [31:0] vals [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
      int sent = 0;
      int calls = 0;
      int popped = 0;
      int stall_hits = 0;
      logic pend = 1'b0;
      logic [31:0] pend_val = '0;
      for (int c = 0; c < 200 && popped < 4; c++) begin
         job_valid = (sent < 4); job_idx = 32'(200 + sent);
         comp_done = pend; comp_returndata = pend_val;
         if (pend) exp_q.push_back(pend_val);
         res_ready = 1'($urandom_range(0, 1));
         #1;
         if (comp_done && comp_stall) stall_hits++;
         if (res_valid && res_ready) begin
            n_checks++;
            if (res_data !== exp_q[0]) begin
               n_fail++; $display("FAIL order_pop%0d: got %h want %h", popped, res_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            popped++;
         end
         if (job_valid && job_ready) sent++;
         pend = comp_start && !comp_busy && calls < 4;
         if (pend) begin
            pend_val = vals[calls];
            calls++;
         end
         tick();
      end
      comp_done = 1'b0; res_ready = 1'b0; job_valid = 1'b0;
      #1;
      n_checks++;
      if (popped != 4) begin
         n_fail++; $display("FAIL order_count: popped %0d want 4", popped);
      end
      n_checks++;
      if (stall_hits != 0) begin
         n_fail++; $display("FAIL order_stall: %0d stalled returns want 0", stall_hits);
      end
      n_checks++;
      if (outstanding !== 3'd0) begin
         n_fail++; $display("FAIL order_out: got %0d want 0", outstanding);
      end
   endtask

   task automatic test_push_pop_same_cycle();
      job_valid = 1'b1; job_idx = 32'd1;
      tick();
      job_valid = 1'b0;
      tick();
      comp_done = 1'b1; comp_returndata = 32'h111; exp_q.push_back(32'h111);
      tick();
      comp_done = 1'b0; job_valid = 1'b1; job_idx = 32'd2;
      tick();
      job_valid = 1'b0;
      tick();
      comp_done = 1'b1; comp_returndata = 32'h222; res_ready = 1'b1;
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
         n_fail++; $display("FAIL pushpop_head: valid %b data %h want 1 %h", res_valid, res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(32'h222);
      tick();
      comp_done = 1'b0; res_ready = 1'b0;
      #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[0] || outstanding !== 3'd1) begin
         n_fail++; $display("FAIL pushpop_next: valid %b data %h out %0d want 1 %h 1",
                            res_valid, res_data, outstanding, exp_q[0]);
      end
      void'(exp_q.pop_front());
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_checks++;
      if (res_valid !== 1'b0 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL pushpop_empty: valid %b out %0d want 0 0", res_valid, outstanding);
      end
   endtask

   task automatic test_protocol_violation();
      comp_done = 1'b1; comp_returndata = 32'hDEAD;
      tick();
      comp_done = 1'b0;
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || outstanding !== 3'd0 || comp_stall !== 1'b0) begin
         n_fail++; $display("FAIL spurious_done: valid %b out %0d stall %b want 0 0 0",
                            res_valid, outstanding, comp_stall);
      end
   endtask

   task automatic test_reset_mid();
      job_valid = 1'b1; job_idx = 32'd10;
      tick();
      job_idx = 32'd11;
      tick();
      job_valid = 1'b0;
      comp_done = 1'b1; comp_returndata = 32'h10;
      tick();
      comp_returndata = 32'h11;
      tick();
      comp_done = 1'b0; comp_busy = 1'b1; job_valid = 1'b1; job_idx = 32'd12;
      tick();
      job_valid = 1'b0;
      n_checks++;
      if (comp_start !== 1'b1 || res_valid !== 1'b1 || outstanding !== 3'd3) begin
         n_fail++; $display("FAIL rstmid_setup: start %b valid %b out %0d want 1 1 3",
                            comp_start, res_valid, outstanding);
      end
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if ({comp_start, res_valid, comp_stall, timeout_err, job_ready} !== 5'b0 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL rstmid_flags: %b out %0d want 00000 0",
                            {comp_start, res_valid, comp_stall, timeout_err, job_ready}, outstanding);
      end
      n_checks++;
      if ({comp_idx, comp_num_clusters, comp_num_dim, res_data} !== 128'h0) begin
         n_fail++; $display("FAIL rstmid_values: %h %h %h %h want 0",
                            comp_idx, comp_num_clusters, comp_num_dim, res_data);
      end
      exp_q.delete();
      comp_busy = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || job_ready !== 1'b1 || comp_start !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_release: valid %b ready %b start %b want 0 1 0",
                            res_valid, job_ready, comp_start);
      end
   endtask

`ifdef KMEANS_DRV_TIMEOUT_EN
   task automatic test_timeout();
      job_valid = 1'b1; job_idx = 32'h55;
      tick();
      job_valid = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_early: got %b want 0", timeout_err);
      end
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if (timeout_err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_set: got %b want 1", timeout_err);
      end
      comp_done = 1'b1; comp_returndata = 32'h5555; exp_q.push_back(32'h5555);
      tick();
      comp_done = 1'b0; res_ready = 1'b1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
         n_fail++; $display("FAIL timeout_result: valid %b data %h want 1 %h", res_valid, res_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      tick();
      res_ready = 1'b0;
      n_checks++;
      if (timeout_err !== 1'b1 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL timeout_sticky: err %b out %0d want 1 0", timeout_err, outstanding);
      end
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_job();
      test_busy_hold();
      test_credit_limit();
      test_ordering();
      test_push_pop_same_cycle();
      test_protocol_violation();
      test_reset_mid();
`ifdef KMEANS_DRV_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
